// File: rtl/rv32i_mem_stage.sv
// rv32i memory-access stage: takes EX results, runs load/store transfers on a
// req/gnt/rvalid data bus and hands aligned results to writeback.
package rv32i_mem_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        logic [1:0]  wb_sel;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        reg_write;
    } ex_mem_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [4:0]  rd_addr;
        logic [1:0]  wb_sel;
        logic        reg_write;
    } mem_wb_payload_t;
endpackage

module rv32i_mem_stage
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned RVALID_TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  ex_mem_payload_t ex_payload_i,
    output logic            dmem_req_o,
    input  logic            dmem_gnt_i,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [31:0]     dmem_addr_o,
    output logic [31:0]     dmem_wdata_o,
    input  logic            dmem_rvalid_i,
    input  logic [31:0]     dmem_rdata_i,
    input  logic            dmem_err_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output mem_wb_payload_t wb_payload_o,
    output logic [1:0]      mem_fault_o,
    output logic            busy_o
);
    localparam int CNT_W = (RVALID_TIMEOUT > 0) ? $clog2(RVALID_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    mem_wb_payload_t hold_pl;
    logic [1:0]      hold_size;
    logic            hold_uns;
    logic            hold_read;
    logic [1:0]      hold_off;
    logic [CNT_W-1:0] cnt;

    logic            accept;
    logic            is_mem;
    logic            misaligned;
    logic            timeout_hit;
    logic [3:0]      be_calc;
    logic [31:0]     wdata_calc;
    logic [31:0]     shifted;
    logic [31:0]     load_calc;
    mem_wb_payload_t direct_pl;
    mem_wb_payload_t resp_pl;
    mem_wb_payload_t tmo_pl;

    assign ex_ready_o = (state == IDLE) && (!wb_valid_o || wb_ready_i);
    assign accept     = ex_valid_i && ex_ready_o;
    assign busy_o     = (state != IDLE);
    assign is_mem     = ex_payload_i.mem_read || ex_payload_i.mem_write;
    assign misaligned = is_mem &&
                        (((ex_payload_i.mem_size == 2'b01) && ex_payload_i.alu_result[0]) ||
                         ((ex_payload_i.mem_size == 2'b10) && (ex_payload_i.alu_result[1:0] != 2'b00)));
    assign timeout_hit = (RVALID_TIMEOUT != 0) &&
                         ({{(32-CNT_W){1'b0}}, cnt} + 32'd1 >= RVALID_TIMEOUT);

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = ex_payload_i.rs2_data;
        case (ex_payload_i.mem_size)
            2'b00: begin
                be_calc    = 4'b0001 << ex_payload_i.alu_result[1:0];
                wdata_calc = {4{ex_payload_i.rs2_data[7:0]}};
            end
            2'b01: begin
                be_calc    = ex_payload_i.alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{ex_payload_i.rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load alignment works from the held offset since the bus response arrives later.
    always_comb begin
        shifted   = dmem_rdata_i >> {hold_off, 3'b000};
        load_calc = shifted;
        case (hold_size)
            2'b00:   load_calc = hold_uns ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_calc = hold_uns ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        direct_pl.pc         = ex_payload_i.pc;
        direct_pl.pc_plus4   = ex_payload_i.pc_plus4;
        direct_pl.alu_result = ex_payload_i.alu_result;
        direct_pl.load_data  = 32'b0;
        direct_pl.rd_addr    = ex_payload_i.rd_addr;
        direct_pl.wb_sel     = ex_payload_i.wb_sel;
        direct_pl.reg_write  = ex_payload_i.reg_write && !misaligned;

        resp_pl              = hold_pl;
        resp_pl.load_data    = (hold_read && !dmem_err_i) ? load_calc : 32'b0;
        resp_pl.reg_write    = hold_pl.reg_write && !dmem_err_i;

        tmo_pl               = hold_pl;
        tmo_pl.load_data     = 32'b0;
        tmo_pl.reg_write     = 1'b0;
    end

    // Single FSM owning bus outputs, the holding register and the output slot.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            hold_pl      <= '0;
            hold_size    <= 2'b00;
            hold_uns     <= 1'b0;
            hold_read    <= 1'b0;
            hold_off     <= 2'b00;
            cnt          <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= 4'b0;
            dmem_addr_o  <= 32'b0;
            dmem_wdata_o <= 32'b0;
            wb_valid_o   <= 1'b0;
            wb_payload_o <= '0;
            mem_fault_o  <= 2'b00;
        end else begin
            if (wb_ready_i) begin
                wb_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_pl   <= direct_pl;
                        hold_size <= ex_payload_i.mem_size;
                        hold_uns  <= ex_payload_i.mem_unsigned;
                        hold_read <= ex_payload_i.mem_read;
                        hold_off  <= ex_payload_i.alu_result[1:0];
                        if (!is_mem || misaligned) begin
                            wb_valid_o   <= 1'b1;
                            wb_payload_o <= direct_pl;
                            mem_fault_o  <= misaligned ? 2'b01 : 2'b00;
                        end else begin
                            state        <= REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= ex_payload_i.mem_write;
                            dmem_be_o    <= be_calc;
                            dmem_addr_o  <= {ex_payload_i.alu_result[31:2], 2'b00};
                            dmem_wdata_o <= wdata_calc;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        state      <= WAIT;
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        cnt        <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state        <= IDLE;
                        wb_valid_o   <= 1'b1;
                        wb_payload_o <= resp_pl;
                        mem_fault_o  <= dmem_err_i ? 2'b10 : 2'b00;
                    end else if (timeout_hit) begin
                        state        <= IDLE;
                        wb_valid_o   <= 1'b1;
                        wb_payload_o <= tmo_pl;
                        mem_fault_o  <= 2'b11;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Directed bench for rv32i_mem_stage; expected writeback results are queued
// when an op is issued and compared when the output slot fills.
module tb_rv32i_mem_stage;
    import rv32i_mem_pkg::*;

    typedef struct {
        mem_wb_payload_t pl;
        logic [1:0]      fault;
    } exp_t;

    logic            clk;
    logic            rst_ni;
    logic            ex_valid;
    logic            ex_ready;
    ex_mem_payload_t ex_payload;
    logic            dmem_req;
    logic            dmem_gnt;
    logic            dmem_we;
    logic [3:0]      dmem_be;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_wdata;
    logic            dmem_rvalid;
    logic [31:0]     dmem_rdata;
    logic            dmem_err;
    logic            wb_valid;
    logic            wb_ready;
    mem_wb_payload_t wb_payload;
    logic [1:0]      mem_fault;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rv32i_mem_stage #(.RVALID_TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid),
        .ex_ready_o   (ex_ready),
        .ex_payload_i (ex_payload),
        .dmem_req_o   (dmem_req),
        .dmem_gnt_i   (dmem_gnt),
        .dmem_we_o    (dmem_we),
        .dmem_be_o    (dmem_be),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_rvalid_i(dmem_rvalid),
        .dmem_rdata_i (dmem_rdata),
        .dmem_err_i   (dmem_err),
        .wb_valid_o   (wb_valid),
        .wb_ready_i   (wb_ready),
        .wb_payload_o (wb_payload),
        .mem_fault_o  (mem_fault),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ex_mem_payload_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                           input logic [31:0] rs2, input logic [4:0] rd,
                                           input logic rd_en, input logic wr_en,
                                           input logic [1:0] size, input logic uns,
                                           input logic rw);
        ex_mem_payload_t p;
        p.pc           = pc;
        p.pc_plus4     = pc + 32'd4;
        p.alu_result   = alu;
        p.rs2_data     = rs2;
        p.rd_addr      = rd;
        p.wb_sel       = rd_en ? 2'b01 : 2'b00;
        p.mem_read     = rd_en;
        p.mem_write    = wr_en;
        p.mem_size     = size;
        p.mem_unsigned = uns;
        p.reg_write    = rw;
        return p;
    endfunction

    // Reference behaviour: picks bytes/halves directly out of the response word.
    function automatic exp_t model(input ex_mem_payload_t p, input logic [31:0] rdata,
                                   input logic err, input logic tmo);
        exp_t        e;
        logic [7:0]  b;
        logic [15:0] h;
        logic        mis;
        e.pl.pc         = p.pc;
        e.pl.pc_plus4   = p.pc_plus4;
        e.pl.alu_result = p.alu_result;
        e.pl.load_data  = 32'b0;
        e.pl.rd_addr    = p.rd_addr;
        e.pl.wb_sel     = p.wb_sel;
        e.pl.reg_write  = p.reg_write;
        e.fault         = 2'b00;
        mis = (p.mem_read || p.mem_write) &&
              ((p.mem_size == 2'b01 && p.alu_result[0]) ||
               (p.mem_size == 2'b10 && p.alu_result[1:0] != 2'b00));
        case (p.alu_result[1:0])
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = p.alu_result[1] ? rdata[31:16] : rdata[15:0];
        if (mis) begin
            e.fault = 2'b01;
            e.pl.reg_write = 1'b0;
        end else if (tmo) begin
            e.fault = 2'b11;
            e.pl.reg_write = 1'b0;
        end else if (err) begin
            e.fault = 2'b10;
            e.pl.reg_write = 1'b0;
        end else if (p.mem_read) begin
            if (p.mem_size == 2'b00)
                e.pl.load_data = p.mem_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            else if (p.mem_size == 2'b01)
                e.pl.load_data = p.mem_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            else
                e.pl.load_data = rdata;
        end
        return e;
    endfunction

    // Present one op and hold it until accepted; returns at the negedge after acceptance.
    task automatic applyStimulus(input ex_mem_payload_t p);
        int n;
        n = 0;
        ex_payload = p;
        ex_valid   = 1'b1;
        #1;
        while (!ex_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("accept_ready", 32'(ex_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    // Grant in the current cycle, then respond after rv_delay idle cycles.
    task automatic bus_xfer(input int rv_delay, input logic [31:0] rdata, input logic err);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        repeat (rv_delay) @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        dmem_err    = err;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_err    = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        checkOutput({tag, "_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_pc"}, wb_payload.pc, e.pl.pc);
            checkOutput({tag, "_pc4"}, wb_payload.pc_plus4, e.pl.pc_plus4);
            checkOutput({tag, "_alu"}, wb_payload.alu_result, e.pl.alu_result);
            checkOutput({tag, "_load"}, wb_payload.load_data, e.pl.load_data);
            checkOutput({tag, "_rd"}, 32'(wb_payload.rd_addr), 32'(e.pl.rd_addr));
            checkOutput({tag, "_wbsel"}, 32'(wb_payload.wb_sel), 32'(e.pl.wb_sel));
            checkOutput({tag, "_rw"}, 32'(wb_payload.reg_write), 32'(e.pl.reg_write));
            checkOutput({tag, "_fault"}, 32'(mem_fault), 32'(e.fault));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(ex_ready), 32'd1);
        checkOutput({tag, "_req"}, 32'(dmem_req), 32'd0);
        checkOutput({tag, "_we"}, 32'(dmem_we), 32'd0);
        checkOutput({tag, "_be"}, 32'(dmem_be), 32'd0);
        checkOutput({tag, "_addr"}, dmem_addr, 32'd0);
        checkOutput({tag, "_wdata"}, dmem_wdata, 32'd0);
        checkOutput({tag, "_wbvalid"}, 32'(wb_valid), 32'd0);
        checkOutput({tag, "_payload_nz"}, 32'(|wb_payload), 32'd0);
        checkOutput({tag, "_fault"}, 32'(mem_fault), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        ex_mem_payload_t p;
        ex_mem_payload_t p2;
        int n;
        rst_ni      = 1'b0;
        ex_valid    = 1'b0;
        ex_payload  = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'b0;
        dmem_err    = 1'b0;
        wb_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk);

        $display("[TB] ALU op passes straight through");
        p = mk(32'h1000, 32'h1234, 32'h0, 5'd3, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
        sb.push_back(model(p, 32'h0, 1'b0, 1'b0));
        applyStimulus(p);
        checkOutput("alu_noreq", 32'(dmem_req), 32'd0);
        pop_check("alu");

        $display("[TB] back-to-back ALU ops replace the slot");
        p = mk(32'h1004, 32'h5555, 32'h0, 5'd4, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
        sb.push_back(model(p, 32'h0, 1'b0, 1'b0));
        applyStimulus(p);
        pop_check("replace");
        @(negedge clk);
        checkOutput("slot_drained", 32'(wb_valid), 32'd0);

        $display("[TB] SB with stalled grant");
        p = mk(32'h1008, 32'h103, 32'hAB, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        sb.push_back(model(p, 32'h0, 1'b0, 1'b0));
        applyStimulus(p);
        for (int i = 0; i < 3; i++) begin
            checkOutput("sb_req", 32'(dmem_req), 32'd1);
            checkOutput("sb_we", 32'(dmem_we), 32'd1);
            checkOutput("sb_addr", dmem_addr, 32'h100);
            checkOutput("sb_be", 32'(dmem_be), 32'b1000);
            checkOutput("sb_wdata", dmem_wdata, 32'hABABABAB);
            @(negedge clk);
        end
        checkOutput("sb_req_held", 32'(dmem_req), 32'd1);
        bus_xfer(0, 32'hDEADBEEF, 1'b0);
        pop_check("sb");

        $display("[TB] byte and half loads at minimum latency");
        p = mk(32'h100C, 32'h102, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        sb.push_back(model(p, 32'h0080_0000, 1'b0, 1'b0));
        applyStimulus(p);
        checkOutput("lb_req", 32'(dmem_req), 32'd1);
        checkOutput("lb_be", 32'(dmem_be), 32'b0100);
        bus_xfer(0, 32'h0080_0000, 1'b0);
        pop_check("lb");
        checkOutput("lb_load_const", wb_payload.load_data, 32'hFFFFFF80);

        p = mk(32'h1010, 32'h102, 32'h0, 5'd6, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        sb.push_back(model(p, 32'h0080_0000, 1'b0, 1'b0));
        applyStimulus(p);
        bus_xfer(0, 32'h0080_0000, 1'b0);
        pop_check("lbu");
        checkOutput("lbu_load_const", wb_payload.load_data, 32'h00000080);

        p = mk(32'h1014, 32'h102, 32'h0, 5'd7, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        sb.push_back(model(p, 32'h8001_0000, 1'b0, 1'b0));
        applyStimulus(p);
        checkOutput("lh_be", 32'(dmem_be), 32'b1100);
        bus_xfer(1, 32'h8001_0000, 1'b0);
        pop_check("lh");
        checkOutput("lh_load_const", wb_payload.load_data, 32'hFFFF8001);

        p = mk(32'h1018, 32'h200, 32'h0, 5'd8, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        sb.push_back(model(p, 32'hCAFEF00D, 1'b0, 1'b0));
        applyStimulus(p);
        bus_xfer(2, 32'hCAFEF00D, 1'b0);
        pop_check("lw");

        $display("[TB] misaligned word load");
        p = mk(32'h101C, 32'h101, 32'h0, 5'd9, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        sb.push_back(model(p, 32'h0, 1'b0, 1'b0));
        applyStimulus(p);
        checkOutput("mis_noreq", 32'(dmem_req), 32'd0);
        checkOutput("mis_busy", 32'(busy), 32'd0);
        pop_check("mis");

        $display("[TB] bus error and timeout");
        p = mk(32'h1020, 32'h300, 32'h0, 5'd10, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        sb.push_back(model(p, 32'h1111_2222, 1'b1, 1'b0));
        applyStimulus(p);
        bus_xfer(0, 32'h1111_2222, 1'b1);
        pop_check("err");

        p = mk(32'h1024, 32'h304, 32'h0, 5'd11, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        sb.push_back(model(p, 32'h0, 1'b0, 1'b1));
        applyStimulus(p);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        n = 0;
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tmo_in_bound", 32'(n < 20), 32'd1);
        pop_check("tmo");
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_7777;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checkOutput("late_rvalid_wbvalid", 32'(wb_valid), 32'd0);
        checkOutput("late_rvalid_busy", 32'(busy), 32'd0);

        $display("[TB] second load held off while slot is full");
        wb_ready = 1'b0;
        p = mk(32'h1028, 32'h400, 32'h0, 5'd12, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        sb.push_back(model(p, 32'h0A0B_0C0D, 1'b0, 1'b0));
        applyStimulus(p);
        bus_xfer(0, 32'h0A0B_0C0D, 1'b0);
        pop_check("ld1");
        p2 = mk(32'h102C, 32'h404, 32'h0, 5'd13, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        ex_payload = p2;
        ex_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("ld2_blocked_ready", 32'(ex_ready), 32'd0);
            checkOutput("ld2_blocked_req", 32'(dmem_req), 32'd0);
            checkOutput("ld2_slot_held", 32'(wb_valid), 32'd1);
        end
        wb_ready = 1'b1;
        #1;
        checkOutput("ld2_ready_comb", 32'(ex_ready), 32'd1);
        sb.push_back(model(p2, 32'hF0E1_D2C3, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        checkOutput("ld2_req", 32'(dmem_req), 32'd1);
        checkOutput("ld2_slot_consumed", 32'(wb_valid), 32'd0);
        bus_xfer(0, 32'hF0E1_D2C3, 1'b0);
        pop_check("ld2");
        @(negedge clk);

        $display("[TB] reset during WAIT");
        p = mk(32'h1030, 32'h500, 32'h0, 5'd14, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        applyStimulus(p);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        checkOutput("wait_busy", 32'(busy), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_ni      = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checkOutput("post_reset_rvalid_ignored", 32'(wb_valid), 32'd0);
        checkOutput("sb_empty_at_end", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32i_mem_stage.md
# rv32i_mem_stage

Memory-access stage of the rv32i pipeline, directly downstream of the execute stage. It accepts the `ex_mem_payload_t` bundle with a valid/ready handshake and performs load/store transfers on a req/gnt/rvalid data bus. It generates byte enables, replicates store data and aligns/extends load data. Results go to writeback through a registered `mem_wb_payload_t` output slot with valid/ready.

## Interface
- `RVALID_TIMEOUT`, default 255: maximum cycles from grant to `dmem_rvalid_i`; 0 disables the timeout.

- `clk_i` in 1: clock. One clock domain only; all state updates on its rising edge.
- `rst_ni` in 1: reset, synchronous and active-low.
- `ex_valid_i` in 1: payload valid from EX.
- `ex_ready_o` out 1: stage can accept.
- `ex_payload_i` in `ex_mem_payload_t`: uses `pc`, `pc_plus4`, `alu_result`, `rs2_data`, `rd_addr`, `wb_sel`, `mem_read`, `mem_write`, `mem_size`, `mem_unsigned`, `reg_write`.
- `dmem_req_o` out 1: bus request.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_we_o` out 1: 1 = store.
- `dmem_be_o` out 4: byte enables.
- `dmem_addr_o` out 32: word address, `{alu_result[31:2],2'b00}`.
- `dmem_wdata_o` out 32: store data.
- `dmem_rvalid_i` in 1: response valid.
- `dmem_rdata_i` in 32: load data.
- `dmem_err_i` in 1: response error, qualified by `dmem_rvalid_i`.
- `wb_valid_o` out 1: output slot valid.
- `wb_ready_i` in 1: WB consumes the slot.
- `wb_payload_o` out `mem_wb_payload_t`: `pc`, `pc_plus4`, `alu_result`, `load_data`, `rd_addr`, `wb_sel`, `reg_write`.
- `mem_fault_o` out 2: fault code with the slot. 00 none, 01 misaligned, 10 bus error, 11 timeout.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT.
- `ex_ready_o` = IDLE && (!`wb_valid_o` || `wb_ready_i`). Accept = `ex_valid_i` && `ex_ready_o`.
- On accept, the payload is captured into an internal holding register.
- **Non-memory op:** goes straight to the output slot. FSM stays IDLE.
- **Misaligned op:** half with `addr[0]`=1, or word with `addr[1:0]`≠0. No bus access. Goes to the slot with fault 01 and `reg_write` forced to 0.
- **Aligned mem op:** IDLE→REQ.
- **REQ state:**
  - `dmem_req_o`=1; addr, we, be and wdata held constant until grant.
  - On `dmem_gnt_i`: →WAIT and the timeout counter clears.
- **WAIT state:**
  - On `dmem_rvalid_i`: the slot is loaded, then →IDLE.
  - If `dmem_err_i`=1: fault 10 and `reg_write` forced to 0.
  - If the counter reaches `RVALID_TIMEOUT`: fault 11, `reg_write` forced to 0, →IDLE.
  - A late `dmem_rvalid_i` arriving in IDLE or REQ is ignored.
- Loads are not issued while the slot is occupied, because `ex_ready_o` gating guarantees the slot is free on completion.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`
  - half: `addr[1]` ? 1100 : 0011
  - word: 1111
- **Store data:**
  - byte: `{4{rs2[7:0]}}`
  - half: `{2{rs2[15:0]}}`
  - word: `rs2`
- **Load data:**
  - Shift: `dmem_rdata_i >> (8*addr[1:0])`.
  - Extend byte/half: sign-extend, or zero-extend if `mem_unsigned`.
  - Stores write `load_data`=0.
- **Output slot:**
  - Set on load.
  - Cleared on `wb_ready_i` if not reloaded in the same cycle.
  - Simultaneous consume and reload replaces the contents with `wb_valid_o` staying 1.

## Timing
- **Reset values:**
  - `ex_ready_o`=1 (IDLE, slot empty).
  - `dmem_req_o`=0, `dmem_we_o`=0, `dmem_be_o`=0, `dmem_addr_o`=0, `dmem_wdata_o`=0.
  - `wb_valid_o`=0, `wb_payload_o`='0, `mem_fault_o`=00, `busy_o`=0.
- Reset mid-transaction: the next state is IDLE, `dmem_req_o` drops, the slot clears, and an outstanding response is discarded.
- Non-memory or misaligned op: accepted at cycle N, `wb_valid_o` at N+1.
- Memory op: accepted at N, `dmem_req_o` at N+1.
  - With grant at N+1 and rvalid at N+2, `wb_valid_o` is at N+3 (minimum).
  - Each cycle of grant stall or response delay adds one cycle.
- Bus outputs are registered; `dmem_req_o` has no combinational path from `ex_valid_i`.
- `ex_ready_o` is combinational on `wb_ready_i`.
- Timeout counter width is `$clog2(RVALID_TIMEOUT+1)` and it saturates rather than wrapping.

## Test plan
- ALU op, `alu_result`=0x1234, `wb_ready_i`=1 → `wb_valid_o` one cycle later, `alu_result`=0x1234, fault 00, no `dmem_req_o`.
- SB with addr 0x103, `rs2`=0xAB → `dmem_addr_o`=0x100, be=1000, wdata=0xABABABAB. Grant delayed 3 cycles → req and fields stable throughout.
- LB addr 0x102, rdata 0x0080_0000 → `load_data` 0xFFFFFF80. LBU → 0x00000080. LH addr 0x102, rdata 0x8001_0000 → 0xFFFF8001.
- LW addr 0x101 → no request, fault 01, `reg_write`=0, `wb_valid_o` at N+1.
- `RVALID_TIMEOUT`=4, grant with no rvalid → fault 11 four cycles after grant. Later rvalid ignored. `dmem_err_i` with rvalid → fault 10.
- Two loads back-to-back with `wb_ready_i`=0 → second not accepted until the slot drains. Assert `rst_ni`=0 while in WAIT → IDLE and all outputs at reset values next cycle.
